conversor_bin_bcd: RTL and testbench
====================================

# conversor_bin_bcd

Sequential binary-to-BCD converter that produces the four decimal digits consumed by the 7-segment display controller. It accepts a binary value on a start strobe, runs a shift-and-add-3 (double-dabble) iteration per clock, and loads the four BCD nibbles into held output registers. The outputs connect directly to the display controller's four digit inputs, so they stay stable between conversions.

## Interface
- N_BITS, 14, width of binary input; legal range 4..14; conversion takes N_BITS shift cycles

- i_Clk  input  1  system clock, all state updates on rising edge
- i_Rst  input  1  reset, asynchronous, active-high; clears all state immediately
- i_Inicio  input  1  start strobe; sampled on rising edge while idle
- i_Binario  input  N_BITS  unsigned value to convert, sampled on the same edge as accepted i_Inicio
- o_Ocupado  output  1  high while a conversion is in progress
- o_Listo  output  1  one-cycle pulse: new result present on o_Datos*
- o_Desborde  output  1  last accepted value exceeded 9999 and was clamped
- o_Datos1  output  4  BCD units digit
- o_Datos2  output  4  BCD tens digit
- o_Datos3  output  4  BCD hundreds digit
- o_Datos4  output  4  BCD thousands digit

## Operation
- FSM with two states: REPOSO (idle) and CONVIERTE.
- REPOSO with i_Inicio=1: latch i_Binario into a shift register, clear the 16-bit BCD working register, clear the iteration counter, go to CONVIERTE. If the value is above 9999 (possible only with N_BITS=14), latch 9999 instead and record overflow.
- REPOSO with i_Inicio=0: hold state; all outputs keep their values.
- CONVIERTE, each cycle: every working nibble ≥5 gets +3 (combinational, all four nibbles in parallel), then shift {BCD, binary} left by one, with the binary MSB entering BCD bit 0. Increment the counter.
- On the iteration where counter = N_BITS-1: write the post-shift BCD nibbles to o_Datos1..4, write the recorded overflow flag to o_Desborde, pulse o_Listo, and return to REPOSO.
- i_Inicio while in CONVIERTE is ignored. It is not queued.
- Working-register nibbles never exceed 9 after a shift. No carry out of the thousands digit, because the input is clamped.
- o_Datos* and o_Desborde change only at conversion completion or reset. Intermediate values are never visible on the outputs.

## Timing
- Reset values: o_Datos1..4=0, o_Desborde=0, o_Listo=0, o_Ocupado=0, FSM=REPOSO, counter=0. The display therefore shows 0000 after reset.
- Reset asserted mid-conversion: abort immediately and clear everything to the reset values. No o_Listo is produced, and no start is accepted until i_Rst deasserts.
- Latency: i_Inicio accepted at edge k. Shifts happen on edges k+1 through k+N_BITS. Results and o_Listo are valid after edge k+N_BITS (14 cycles for the default).
- o_Ocupado: high from after edge k through edge k+N_BITS. It is low in the o_Listo cycle.
- o_Listo: high for exactly one cycle, after edge k+N_BITS.
- Back-to-back: i_Inicio held high during the o_Listo cycle is accepted at that edge. Continuous i_Inicio=1 gives one conversion every N_BITS+1 cycles.
- i_Binario only needs to be stable at the accepting edge.

## Test plan
- Reset check: assert i_Rst, release after 20 ns, no start -> o_Datos4..1 = 0,0,0,0; o_Listo, o_Ocupado and o_Desborde stay 0.
- Basic conversion: i_Binario=1579, pulse i_Inicio -> o_Ocupado high for 14 cycles. Then o_Listo pulses once with o_Datos4=1, o_Datos3=5, o_Datos2=7, o_Datos1=9, o_Desborde=0. Outputs hold until the next completion.
- Boundaries: inputs 0, 9, 10, 99, 100, 999, 1000 and 9999 each give the exact decimal digits. 9999 gives 9,9,9,9 with o_Desborde=0.
- Clamp: i_Binario=16383 -> digits 9,9,9,9 and o_Desborde=1. A following conversion of 42 -> 0,0,4,2 and o_Desborde=0.
- Start handling: pulse i_Inicio mid-conversion with a different value -> ignored, and the first result is unchanged. Hold i_Inicio=1 across o_Listo with new value 2048 -> second o_Listo arrives exactly 15 cycles after the first, with 2,0,4,8.
- Reset mid-operation: assert i_Rst at shift cycle 7 of converting 1234 -> outputs immediately 0,0,0,0. No o_Listo follows. A new conversion after release completes normally.

Source files
------------

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the four digit inputs of the 7-segment display controller; the
// digit outputs are held registers that only change when a conversion ends.
module conversor_bin_bcd #(
    parameter int N_BITS = 14
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Inicio,
    input  logic [N_BITS-1:0] i_Binario,
    output logic              o_Ocupado,
    output logic              o_Listo,
    output logic              o_Desborde,
    output logic [3:0]        o_Datos1,
    output logic [3:0]        o_Datos2,
    output logic [3:0]        o_Datos3,
    output logic [3:0]        o_Datos4
);

    localparam int              CNT_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
    localparam logic [31:0]     MAX_DEC  = 32'd9999;

    typedef enum logic {
        REPOSO    = 1'b0,
        CONVIERTE = 1'b1
    } t_estado;

    t_estado r_Estado;
    t_estado w_EstadoSig;

    logic [N_BITS-1:0] r_Bin;
    logic [15:0]       r_Bcd;
    logic [CNT_W-1:0]  r_Cnt;
    logic              r_Ovf;
    logic              r_Listo;
    logic              r_Desborde;
    logic [3:0]        r_Datos1;
    logic [3:0]        r_Datos2;
    logic [3:0]        r_Datos3;
    logic [3:0]        r_Datos4;

    logic              w_Arranque;
    logic              w_Ultimo;
    logic              w_Excede;
    logic [N_BITS-1:0] w_BinCarga;
    logic [15:0]       w_BcdAjuste;
    logic [15:0]       w_BcdSig;
    logic [N_BITS-1:0] w_BinSig;

    // Double-dabble correction: a digit of 5 or more becomes >= 10 after the
    // shift, so adding 3 beforehand makes the carry land in the next digit.
    function automatic logic [3:0] f_Suma3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    assign w_Arranque = (r_Estado == REPOSO) && i_Inicio;
    assign w_Ultimo   = (r_Estado == CONVIERTE) && (r_Cnt == CNT_LAST);

    // Only a 14-bit input can exceed four decimal digits; clamp to 9999.
    assign w_Excede   = 32'(i_Binario) > MAX_DEC;
    assign w_BinCarga = w_Excede ? N_BITS'(MAX_DEC) : i_Binario;

    assign w_BcdAjuste = {f_Suma3(r_Bcd[15:12]), f_Suma3(r_Bcd[11:8]),
                          f_Suma3(r_Bcd[7:4]),   f_Suma3(r_Bcd[3:0])};
    assign w_BcdSig    = {w_BcdAjuste[14:0], r_Bin[N_BITS-1]};
    assign w_BinSig    = {r_Bin[N_BITS-2:0], 1'b0};

    // FSM state register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_Estado <= REPOSO;
        else       r_Estado <= w_EstadoSig;
    end

    // FSM next state: start only from idle, return to idle on the last shift
    always_comb begin
        w_EstadoSig = r_Estado;
        case (r_Estado)
            REPOSO:    if (i_Inicio) w_EstadoSig = CONVIERTE;
            CONVIERTE: if (w_Ultimo) w_EstadoSig = REPOSO;
            default:   w_EstadoSig = REPOSO;
        endcase
    end

    // Working registers, iteration counter and held result registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Bin      <= '0;
            r_Bcd      <= '0;
            r_Cnt      <= '0;
            r_Ovf      <= 1'b0;
            r_Listo    <= 1'b0;
            r_Desborde <= 1'b0;
            r_Datos1   <= 4'd0;
            r_Datos2   <= 4'd0;
            r_Datos3   <= 4'd0;
            r_Datos4   <= 4'd0;
        end else begin
            r_Listo <= 1'b0;
            if (w_Arranque) begin
                r_Bin <= w_BinCarga;
                r_Bcd <= '0;
                r_Cnt <= '0;
                r_Ovf <= w_Excede;
            end else if (r_Estado == CONVIERTE) begin
                r_Bin <= w_BinSig;
                r_Bcd <= w_BcdSig;
                r_Cnt <= r_Cnt + 1'b1;
                if (w_Ultimo) begin
                    r_Datos1   <= w_BcdSig[3:0];
                    r_Datos2   <= w_BcdSig[7:4];
                    r_Datos3   <= w_BcdSig[11:8];
                    r_Datos4   <= w_BcdSig[15:12];
                    r_Desborde <= r_Ovf;
                    r_Listo    <= 1'b1;
                end
            end
        end
    end

    assign o_Ocupado  = (r_Estado == CONVIERTE);
    assign o_Listo    = r_Listo;
    assign o_Desborde = r_Desborde;
    assign o_Datos1   = r_Datos1;
    assign o_Datos2   = r_Datos2;
    assign o_Datos3   = r_Datos3;
    assign o_Datos4   = r_Datos4;

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Directed bench for conversor_bin_bcd (N_BITS = 14): vector table plus
// hand-written sequences for start handling, back-to-back and reset abort.
module tb_conversor_bin_bcd;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Inicio;
    logic [13:0] i_Binario;
    logic        o_Ocupado;
    logic        o_Listo;
    logic        o_Desborde;
    logic [3:0]  o_Datos1;
    logic [3:0]  o_Datos2;
    logic [3:0]  o_Datos3;
    logic [3:0]  o_Datos4;

    int n_cmp = 0;
    int n_err = 0;

    conversor_bin_bcd #(.N_BITS(14)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Inicio   (i_Inicio),
        .i_Binario  (i_Binario),
        .o_Ocupado  (o_Ocupado),
        .o_Listo    (o_Listo),
        .o_Desborde (o_Desborde),
        .o_Datos1   (o_Datos1),
        .o_Datos2   (o_Datos2),
        .o_Datos3   (o_Datos3),
        .o_Datos4   (o_Datos4)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [13:0] bin;
        logic [3:0]  d4, d3, d2, d1;
        logic        ovf;
    } t_vec;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_digits(input string name, input int d4, input int d3,
                                input int d2, input int d1);
        check({name, " d4"}, o_Datos4, d4);
        check({name, " d3"}, o_Datos3, d3);
        check({name, " d2"}, o_Datos2, d2);
        check({name, " d1"}, o_Datos1, d1);
    endtask

    // Walks negedges until o_Listo is seen, counting busy cycles on the way.
    task automatic wait_listo(input string name, output int n_neg, output int n_busy);
        n_neg  = 0;
        n_busy = 0;
        while (!o_Listo && n_neg < 40) begin
            if (o_Ocupado) n_busy++;
            @(negedge i_Clk);
            n_neg++;
        end
        check({name, " listo seen before timeout"}, int'(o_Listo), 1);
    endtask

    task automatic run_conv(input string name, input logic [13:0] v, input int d4,
                            input int d3, input int d2, input int d1, input int ovf);
        int n_neg, n_busy;
        @(negedge i_Clk);
        i_Binario = v;
        i_Inicio  = 1'b1;
        @(negedge i_Clk);
        i_Inicio  = 1'b0;
        check({name, " ocupado after start"}, int'(o_Ocupado), 1);
        wait_listo(name, n_neg, n_busy);
        check({name, " busy cycles"}, n_busy, 14);
        check({name, " ocupado in listo cycle"}, int'(o_Ocupado), 0);
        check_digits(name, d4, d3, d2, d1);
        check({name, " desborde"}, int'(o_Desborde), ovf);
        @(negedge i_Clk);
        check({name, " listo one cycle"}, int'(o_Listo), 0);
    endtask

    task automatic count_listo(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_Clk);
            if (o_Listo) n++;
        end
    endtask

    initial begin
        t_vec vecs[11];
        int n_neg, n_busy, gap, n_l;

        vecs[0]  = '{14'd1579,  4'd1, 4'd5, 4'd7, 4'd9, 1'b0};
        vecs[1]  = '{14'd0,     4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
        vecs[2]  = '{14'd9,     4'd0, 4'd0, 4'd0, 4'd9, 1'b0};
        vecs[3]  = '{14'd10,    4'd0, 4'd0, 4'd1, 4'd0, 1'b0};
        vecs[4]  = '{14'd99,    4'd0, 4'd0, 4'd9, 4'd9, 1'b0};
        vecs[5]  = '{14'd100,   4'd0, 4'd1, 4'd0, 4'd0, 1'b0};
        vecs[6]  = '{14'd999,   4'd0, 4'd9, 4'd9, 4'd9, 1'b0};
        vecs[7]  = '{14'd1000,  4'd1, 4'd0, 4'd0, 4'd0, 1'b0};
        vecs[8]  = '{14'd9999,  4'd9, 4'd9, 4'd9, 4'd9, 1'b0};
        vecs[9]  = '{14'd16383, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        vecs[10] = '{14'd42,    4'd0, 4'd0, 4'd4, 4'd2, 1'b0};

        i_Rst     = 1'b1;
        i_Inicio  = 1'b0;
        i_Binario = '0;
        #20;
        i_Rst = 1'b0;

        // Reset state, no start applied
        repeat (3) @(negedge i_Clk);
        check_digits("reset", 0, 0, 0, 0);
        check("reset listo", int'(o_Listo), 0);
        check("reset ocupado", int'(o_Ocupado), 0);
        check("reset desborde", int'(o_Desborde), 0);

        // Vector table, in order (the clamp entry is followed by 42)
        foreach (vecs[i]) begin
            run_conv($sformatf("vec%0d(%0d)", i, vecs[i].bin), vecs[i].bin,
                     vecs[i].d4, vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].ovf);
        end

        // Outputs hold between conversions
        repeat (5) @(negedge i_Clk);
        check_digits("hold", 0, 0, 4, 2);
        check("hold listo", int'(o_Listo), 0);

        // Start pulse mid-conversion is ignored and not queued
        @(negedge i_Clk);
        i_Binario = 14'd1234;
        i_Inicio  = 1'b1;
        @(negedge i_Clk);
        i_Inicio  = 1'b0;
        repeat (4) @(negedge i_Clk);
        i_Binario = 14'd777;
        i_Inicio  = 1'b1;
        @(negedge i_Clk);
        i_Inicio  = 1'b0;
        i_Binario = '0;
        wait_listo("ignore", n_neg, n_busy);
        check_digits("ignore", 1, 2, 3, 4);
        count_listo(20, n_l);
        check("ignore no queued listo", n_l, 0);
        check("ignore idle", int'(o_Ocupado), 0);

        // Back-to-back with i_Inicio held across o_Listo
        @(negedge i_Clk);
        i_Binario = 14'd3579;
        i_Inicio  = 1'b1;
        @(negedge i_Clk);
        wait_listo("b2b first", n_neg, n_busy);
        check_digits("b2b first", 3, 5, 7, 9);
        i_Binario = 14'd2048;
        @(negedge i_Clk);
        i_Inicio  = 1'b0;
        check("b2b restarted", int'(o_Ocupado), 1);
        wait_listo("b2b second", n_neg, n_busy);
        gap = 1 + n_neg;
        check("b2b gap", gap, 15);
        check_digits("b2b second", 2, 0, 4, 8);

        // Asynchronous reset during shift cycle 7 of 1234
        @(negedge i_Clk);
        i_Binario = 14'd1234;
        i_Inicio  = 1'b1;
        @(negedge i_Clk);
        i_Inicio  = 1'b0;
        repeat (7) @(negedge i_Clk);
        i_Rst = 1'b1;
        #1;
        check_digits("abort", 0, 0, 0, 0);
        check("abort ocupado", int'(o_Ocupado), 0);
        check("abort listo", int'(o_Listo), 0);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        count_listo(20, n_l);
        check("abort no listo", n_l, 0);
        run_conv("after abort", 14'd1234, 1, 2, 3, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
